// File: rtl/note_beat_sequencer_if.sv
// Note handshake and beat-stream bundle between the song reader and note_beat_sequencer.
// The master side drives the note and beat inputs; the slave side is the sequencer.
interface note_beat_sequencer_if #(
  parameter int DUR_W = 6
);
  logic             en;
  logic             beat;
  logic             note_valid;
  logic [DUR_W-1:0] note_dur;
  logic             note_ready;
  logic             note_active;
  logic             note_done;
  logic [DUR_W-1:0] beats_left;

  modport master (
    output en, beat, note_valid, note_dur,
    input  note_ready, note_active, note_done, beats_left
  );

  modport slave (
    input  en, beat, note_valid, note_dur,
    output note_ready, note_active, note_done, beats_left
  );
endinterface

// File: rtl/note_beat_sequencer.sv
// Beat-driven note duration sequencer: accepts one note, counts qualified beats down, pulses done.
// Optional articulation gap after each note: define NOTE_SEQ_GAP_EN.
module note_beat_sequencer #(
  parameter int DUR_W = 6
) (
  input logic                  i_clk,
  input logic                  i_reset,
  note_beat_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DUR_W-1:0] r_beats_left;
  logic [DUR_W-1:0] w_beats_left_next;
  logic             w_ready;
  logic             w_handshake;
  logic             w_qual_beat;

  // Ready is also held low during reset so nothing appears accepted while held.
  assign w_ready     = (r_state == S_REQ) & bus.en & i_reset;
  assign w_handshake = bus.note_valid & w_ready;
  assign w_qual_beat = bus.beat & bus.en;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_REQ;
      r_beats_left <= '0;
    end else begin
      r_state      <= w_state_next;
      r_beats_left <= w_beats_left_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_beats_left_next = r_beats_left;
    case (r_state)
      S_REQ: begin
        if (w_handshake) begin
          if (bus.note_dur != '0) begin
            w_beats_left_next = bus.note_dur;
            w_state_next      = S_PLAY;
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_PLAY: begin
        if (w_qual_beat) begin
          // Counter saturates at zero; the last beat ends the note.
          if (r_beats_left <= DUR_W'(1)) begin
            w_beats_left_next = '0;
`ifdef NOTE_SEQ_GAP_EN
            w_state_next = S_GAP;
`else
            w_state_next = S_DONE;
`endif
          end else begin
            w_beats_left_next = r_beats_left - DUR_W'(1);
          end
        end
      end
      S_GAP: begin
`ifdef NOTE_SEQ_GAP_EN
        if (w_qual_beat) begin
          w_state_next = S_DONE;
        end
`else
        w_state_next = S_REQ;
`endif
      end
      S_DONE: begin
        w_state_next = S_REQ;
      end
      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

  always_comb begin
    bus.note_ready  = w_ready;
    bus.note_active = (r_state == S_PLAY);
    bus.note_done   = (r_state == S_DONE);
    bus.beats_left  = r_beats_left;
  end

endmodule
